pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the F/D/E/W pipeline.
- Each cycle it drives the 2-bit update codes of the fdreg, dereg and ewreg stage registers, plus the PC enable and redirect strobes.
- It serialises multi-cycle execute operations with a wait counter, inserts RAW stalls that the W-stage forwarding path cannot cover, flushes on taken control transfers, and halts on a stop instruction.
- It also keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- WAIT_W, 5: width of the execute wait-time field and of the internal wait counter.
- PERF_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- d_rs  in  6  decode-stage source 1; bit5 = FP file, [4:0] = index
- d_rt  in  6  decode-stage source 2; same encoding as d_rs
- d_uses_rs  in  1  decode instruction reads d_rs
- d_uses_rt  in  1  decode instruction reads d_rt
- de_rw  in  2  execute-stage write type; 00 = none, rw[1] = FP file
- de_rd  in  5  execute-stage destination index
- de_wait_time  in  WAIT_W  extra execute cycles required by the instruction in E
- de_redirect  in  1  instruction in E is a taken branch, jump or jr
- de_stop  in  1  instruction in E is stop
- f_valid  in  1  fetch has a valid instruction this cycle
- fd_update  out  2  update code for fdreg
- de_update  out  2  update code for dereg
- ew_update  out  2  update code for ewreg
- pc_en  out  1  PC register advances or loads this cycle
- pc_redirect  out  1  PC loads the branch target instead of PC+4
- halted  out  1  controller is in HALT
- stall_cnt  out  PERF_W  saturating count of cycles with de_update != ADV

Behaviour:
- Update codes: 00 HOLD, 01 ADV, 10 FLUSH (bubble); 11 is never driven.
- Reset (rstn = 0 at a posedge):
  - state goes to RUN; wait counter cnt = 0; stall_cnt = 0.
  - While rstn = 0 the combinational outputs are all updates = HOLD, pc_en = 0, pc_redirect = 0, halted = 0.
  - Reset mid-WAIT or mid-HALT abandons the operation.
- States are RUN, WAIT and HALT.
- RUN with de_wait_time = N > 0:
  - fd = HOLD, de = HOLD, ew = FLUSH, pc_en = 0.
  - cnt <= N; next state WAIT.
- WAIT with cnt > 1: same outputs as above; cnt <= cnt - 1.
- WAIT with cnt == 1 is the completion cycle: next state RUN, cnt <= 0.
- Net effect: an instruction with wait_time N occupies E for exactly N+1 cycles.
- RUN with de_wait_time = 0 is also a completion cycle.
- Completion cycle: ew = ADV, then the first matching rule applies.
  1. de_stop: fd = FLUSH, de = FLUSH, pc_en = 0; next state HALT.
  2. de_redirect: fd = FLUSH, de = FLUSH, pc_en = 1, pc_redirect = 1.
  3. RAW hazard: fd = HOLD, de = FLUSH, pc_en = 0.
  4. !f_valid: fd = FLUSH, de = ADV, pc_en = 0.
  5. Otherwise: fd = ADV, de = ADV, pc_en = 1, pc_redirect = 0.
- RAW hazard definition: de_rw != 0 and, for either source X in {rs, rt}:
  - d_uses_X = 1,
  - de_rw[1] == d_X[5],
  - de_rd == d_X[4:0],
  - and not (integer file with index 0).
- A RAW hazard always costs exactly one bubble, because the result reaches ewreg and is forwarded on the next cycle.
- de_redirect and de_stop are sampled only in a completion cycle. While waiting they are ignored.
- HALT:
  - all updates = HOLD, pc_en = 0, halted = 1.
  - Exit only through reset.
- stall_cnt:
  - increments by 1 in every non-reset cycle outside HALT where de_update != ADV.
  - saturates at all-ones.
- pc_redirect is 1 only when pc_en is 1.

Decomposition:
- Package pipe_pkg holds:
  - the update-code constants UPD_HOLD, UPD_ADV, UPD_FLUSH;
  - the rw-type constants;
  - the state enum ctrl_state_t {RUN, WAIT, HALT}.
- Sub-module hazard_detect: purely combinational RAW compare of d_rs/d_rt against de_rw/de_rd. It is reused later by the forwarding logic.

Test Plan:
- No hazards, f_valid = 1, all other inputs 0 → every cycle fd/de/ew = 01, pc_en = 1, stall_cnt stays 0.
- de_wait_time = 3 held in E → 3 cycles of fd = de = 00, ew = 10, then a completion cycle with ew = 01, de = 01; 4 E cycles total; stall_cnt = 3.
- de_rw = 01, de_rd = 7, d_rs = 6'd7, d_uses_rs = 1 → one cycle fd = 00, de = 10, pc_en = 0.
  - Same with d_rs = 6'h27 (FP file) → no stall.
  - Same with de_rd = 0, d_rs = 0 → no stall.
- de_redirect = 1 together with a RAW hazard → fd = de = 10, pc_en = 1, pc_redirect = 1 (redirect wins).
- de_wait_time = 2, de_stop = 1 → 2 wait cycles, then the completion cycle with ew = 01, then halted = 1 and all updates 00 indefinitely.
- rstn = 0 during WAIT with cnt = 2 → next cycle state RUN, stall_cnt = 0, halted = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the F/D/E/W pipeline: stage-register update codes,
// execute write types and the controller state enum.
package pipe_pkg;

  localparam logic [1:0] UPD_HOLD  = 2'b00;
  localparam logic [1:0] UPD_ADV   = 2'b01;
  localparam logic [1:0] UPD_FLUSH = 2'b10;

  // rw[1] selects the FP register file; 00 means no write.
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_INT  = 2'b01;
  localparam logic [1:0] RW_FP   = 2'b10;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    HALT
  } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW compare of the decode sources against the execute destination.
// Integer register 0 is hard-wired and never produces a hazard.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [5:0] d_rs_i,
  input  logic [5:0] d_rt_i,
  input  logic       d_uses_rs_i,
  input  logic       d_uses_rt_i,
  input  logic [1:0] de_rw_i,
  input  logic [4:0] de_rd_i,
  output logic       raw_hazard_o
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = d_uses_rs_i && (de_rw_i[1] == d_rs_i[5]) && (de_rd_i == d_rs_i[4:0]) &&
             !((d_rs_i[5] == 1'b0) && (d_rs_i[4:0] == 5'd0));
    rt_hit = d_uses_rt_i && (de_rw_i[1] == d_rt_i[5]) && (de_rd_i == d_rt_i[4:0]) &&
             !((d_rt_i[5] == 1'b0) && (d_rt_i[4:0] == 5'd0));
    raw_hazard_o = (de_rw_i != RW_NONE) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: drives the stage-register update codes and PC
// strobes, serialises multi-cycle execute ops, and counts stall cycles.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned WAIT_W = 5,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [5:0]        d_rs,
  input  logic [5:0]        d_rt,
  input  logic              d_uses_rs,
  input  logic              d_uses_rt,
  input  logic [1:0]        de_rw,
  input  logic [4:0]        de_rd,
  input  logic [WAIT_W-1:0] de_wait_time,
  input  logic              de_redirect,
  input  logic              de_stop,
  input  logic              f_valid,
  output logic [1:0]        fd_update,
  output logic [1:0]        de_update,
  output logic [1:0]        ew_update,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic              halted,
  output logic [PERF_W-1:0] stall_cnt
);

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              raw_hazard;
  logic              complete;

  hazard_detect u_hazard_detect (
    .d_rs_i       (d_rs),
    .d_rt_i       (d_rt),
    .d_uses_rs_i  (d_uses_rs),
    .d_uses_rt_i  (d_uses_rt),
    .de_rw_i      (de_rw),
    .de_rd_i      (de_rd),
    .raw_hazard_o (raw_hazard)
  );

  // The op in E finishes this cycle: either single-cycle in RUN or the last WAIT cycle.
  assign complete = ((state_q == RUN) && (de_wait_time == '0)) ||
                    ((state_q == WAIT) && (cnt_q <= WAIT_W'(1)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (de_wait_time != '0) begin
          state_d = WAIT;
          cnt_d   = de_wait_time;
        end else if (de_stop) begin
          state_d = HALT;
        end
      end
      WAIT: begin
        if (complete) begin
          cnt_d   = '0;
          state_d = de_stop ? HALT : RUN;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      HALT: ;
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    fd_update   = UPD_HOLD;
    de_update   = UPD_HOLD;
    ew_update   = UPD_HOLD;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    halted      = 1'b0;
    if (rstn) begin
      if (state_q == HALT) begin
        halted = 1'b1;
      end else if (!complete) begin
        ew_update = UPD_FLUSH;
      end else begin
        ew_update = UPD_ADV;
        if (de_stop) begin
          fd_update = UPD_FLUSH;
          de_update = UPD_FLUSH;
        end else if (de_redirect) begin
          fd_update   = UPD_FLUSH;
          de_update   = UPD_FLUSH;
          pc_en       = 1'b1;
          pc_redirect = 1'b1;
        end else if (raw_hazard) begin
          de_update = UPD_FLUSH;
        end else if (!f_valid) begin
          fd_update = UPD_FLUSH;
          de_update = UPD_ADV;
        end else begin
          fd_update = UPD_ADV;
          de_update = UPD_ADV;
          pc_en     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != HALT) && (de_update != UPD_ADV) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hand-computed update codes, PC strobes and stall counts.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rstn;
  logic [5:0]  d_rs, d_rt;
  logic        d_uses_rs, d_uses_rt;
  logic [1:0]  de_rw;
  logic [4:0]  de_rd;
  logic [4:0]  de_wait_time;
  logic        de_redirect, de_stop, f_valid;
  logic [1:0]  fd_update, de_update, ew_update;
  logic        pc_en, pc_redirect, halted;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl #(
    .WAIT_W (5),
    .PERF_W (32)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .d_uses_rs    (d_uses_rs),
    .d_uses_rt    (d_uses_rt),
    .de_rw        (de_rw),
    .de_rd        (de_rd),
    .de_wait_time (de_wait_time),
    .de_redirect  (de_redirect),
    .de_stop      (de_stop),
    .f_valid      (f_valid),
    .fd_update    (fd_update),
    .de_update    (de_update),
    .ew_update    (ew_update),
    .pc_en        (pc_en),
    .pc_redirect  (pc_redirect),
    .halted       (halted),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected word packs {fd, de, ew, pc_en, pc_redirect, halted}.
  task automatic chk_out(input string tag, input logic [1:0] fd, input logic [1:0] de,
                         input logic [1:0] ew, input logic pc, input logic red,
                         input logic hlt);
    #1;
    check(tag, {23'd0, fd_update, de_update, ew_update, pc_en, pc_redirect, halted},
          {23'd0, fd, de, ew, pc, red, hlt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_rs = 6'd0; d_rt = 6'd0; d_uses_rs = 1'b0; d_uses_rt = 1'b0;
    de_rw = 2'b00; de_rd = 5'd0; de_wait_time = 5'd0;
    de_redirect = 1'b0; de_stop = 1'b0; f_valid = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    tick();
    chk_out("reset_outputs", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    tick();

    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_out("run_normal", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check("run_no_stall", stall_cnt, 32'd0);

    // Three-cycle wait op held in E
    de_wait_time = 5'd3;
    for (int i = 0; i < 3; i++) begin
      chk_out("wait_stall", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk_out("wait_complete", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    check("wait_stall_cnt", stall_cnt, 32'd3);
    tick();
    de_wait_time = 5'd0;

    // Integer RAW on rs
    de_rw = 2'b01; de_rd = 5'd7; d_rs = 6'd7; d_uses_rs = 1'b1;
    chk_out("raw_int_rs", 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    check("raw_stall_cnt", stall_cnt, 32'd4);

    d_rs = 6'h27;
    chk_out("raw_fp_src_no_stall", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();

    de_rd = 5'd0; d_rs = 6'd0;
    chk_out("raw_r0_no_stall", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();

    d_uses_rs = 1'b0; de_rd = 5'd7; d_rs = 6'd7;
    chk_out("raw_unused_no_stall", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();

    d_rs = 6'd0; d_rt = 6'd7; d_uses_rt = 1'b1;
    chk_out("raw_int_rt", 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();

    de_rw = 2'b10; de_rd = 5'd3; d_rt = 6'd0; d_uses_rt = 1'b0;
    d_rs = 6'h23; d_uses_rs = 1'b1;
    chk_out("raw_fp_rs", 2'b00, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    check("raw_stall_cnt2", stall_cnt, 32'd6);

    idle_inputs();
    f_valid = 1'b0;
    chk_out("fetch_invalid", 2'b10, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    check("fetch_invalid_no_count", stall_cnt, 32'd6);

    // Redirect wins over a RAW hazard
    f_valid = 1'b1;
    de_rw = 2'b01; de_rd = 5'd9; d_rs = 6'd9; d_uses_rs = 1'b1; de_redirect = 1'b1;
    chk_out("redirect_over_raw", 2'b10, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
    tick();
    check("redirect_stall_cnt", stall_cnt, 32'd7);

    // Redirect ignored while waiting, taken at completion
    idle_inputs();
    de_redirect = 1'b1; de_wait_time = 5'd1;
    chk_out("redirect_ignored_in_wait", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("redirect_at_completion", 2'b10, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
    tick();
    check("redirect_wait_stall_cnt", stall_cnt, 32'd9);

    // Stop after a two-cycle wait
    idle_inputs();
    de_wait_time = 5'd2; de_stop = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk_out("stop_wait", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk_out("stop_complete", 2'b10, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    check("stop_stall_cnt", stall_cnt, 32'd12);
    idle_inputs();
    de_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_out("halted", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
      tick();
    end
    check("halt_no_count", stall_cnt, 32'd12);

    // Reset out of HALT, then reset in the middle of a wait
    rstn = 1'b0;
    idle_inputs();
    tick();
    rstn = 1'b1;
    chk_out("after_halt_reset", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    check("after_halt_reset_cnt", stall_cnt, 32'd0);
    de_wait_time = 5'd3;
    tick();
    chk_out("wait_before_reset", 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    rstn = 1'b0;
    de_wait_time = 5'd0;
    chk_out("reset_mid_wait_outputs", 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    rstn = 1'b1;
    check("reset_mid_wait_cnt", stall_cnt, 32'd0);
    chk_out("reset_mid_wait_run", 2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    check("final_stall_cnt", stall_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
